// File: rtl/peridot_phy_rxd_ex.sv
// UART receiver: 3-stage synchroniser, 2-of-3 mid-bit majority vote, optional parity,
// 1 or 2 stop bits, break detection and a one-deep output holding register.
module peridot_phy_rxd_ex #(
    parameter int unsigned CLOCK_FREQUENCY = 50000000,
    parameter int unsigned UART_BAUDRATE   = 115200,
    parameter int unsigned DATA_BITS       = 8,
    parameter int unsigned PARITY_MODE     = 0,
    parameter int unsigned STOP_BITS       = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [DATA_BITS-1:0] out_data,
    output logic [2:0]           out_error,
    output logic                 out_overrun,
    input  logic                 rxd
);
    localparam int unsigned DIV_W  = 12;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DIVNUM = CLOCK_FREQUENCY / UART_BAUDRATE - 1;
    localparam int unsigned HALF   = DIVNUM / 2;

    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIVNUM);
    localparam logic [DIV_W-1:0] SMP_FIRST  = DIV_W'(HALF + 1);
    localparam logic [DIV_W-1:0] SMP_MID    = DIV_W'(HALF);
    localparam logic [DIV_W-1:0] SMP_LAST   = DIV_W'(HALF - 1);
    localparam logic [DIV_W-1:0] DECIDE     = DIV_W'(HALF - 2);
    localparam logic [CNT_W-1:0] LAST_DATA  = CNT_W'(DATA_BITS);
    localparam logic             LAST_STOP  = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [2:0]           sync_q, sync_d;
    logic [2:0]           smp_q, smp_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 zero_q, zero_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 brk_q, brk_d;
    logic                 valid_q, valid_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [2:0]           err_q, err_d;
    logic                 ovr_q, ovr_d;
    logic                 frame_done;
    logic [2:0]           frame_err;

    logic line_c, fall_c, wrap_c, decide_c, sample_c, vote_c;

    assign line_c   = sync_q[2];
    assign fall_c   = (sync_q[2:1] == 2'b10);
    assign wrap_c   = (div_q == '0);
    assign decide_c = (div_q == DECIDE);
    assign sample_c = (div_q == SMP_FIRST) || (div_q == SMP_MID) || (div_q == SMP_LAST);
    assign vote_c   = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

    // Frame sequencing, bit resolution and output handshake
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        sync_d     = {sync_q[1:0], rxd};
        smp_d      = smp_q;
        cnt_d      = cnt_q;
        stop_d     = stop_q;
        shift_d    = shift_q;
        par_d      = par_q;
        zero_d     = zero_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        brk_d      = brk_q;
        valid_d    = valid_q;
        data_d     = data_q;
        err_d      = err_q;
        ovr_d      = 1'b0;
        frame_done = 1'b0;
        frame_err  = 3'b000;

        if (state_q != S_IDLE) begin
            div_d = wrap_c ? DIV_RELOAD : div_q - DIV_W'(1);
            if (sample_c) smp_d = {smp_q[1:0], line_c};
        end

        case (state_q)
            S_IDLE: begin
                if (fall_c) begin
                    state_d = S_START;
                    div_d   = DIV_RELOAD;
                    cnt_d   = '0;
                    stop_d  = 1'b0;
                    shift_d = '0;
                    par_d   = 1'b0;
                    zero_d  = 1'b1;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    brk_d   = 1'b0;
                end
            end
            S_START: begin
                if (decide_c && vote_c) state_d = S_IDLE;
                else if (wrap_c)        state_d = S_DATA;
            end
            S_DATA: begin
                if (decide_c) begin
                    shift_d = {vote_c, shift_q[DATA_BITS-1:1]};
                    par_d   = par_q ^ vote_c;
                    zero_d  = zero_q & ~vote_c;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
                if (wrap_c && cnt_q == LAST_DATA)
                    state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (decide_c) begin
                    perr_d = (PARITY_MODE == 1) ? ~(par_q ^ vote_c) : (par_q ^ vote_c);
                    zero_d = zero_q & ~vote_c;
                end
                if (wrap_c) state_d = S_STOP;
            end
            S_STOP: begin
                // The frame ends at the decision point of the last stop bit
                if (decide_c) begin
                    ferr_d = ferr_q | ~vote_c;
                    if (stop_q == 1'b0) brk_d = zero_q & ~vote_c;
                    if (stop_q == LAST_STOP) begin
                        frame_done = 1'b1;
                        frame_err  = {brk_d, perr_q, ferr_d};
                        state_d    = brk_d ? S_BREAK : S_IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            S_BREAK: begin
                if (line_c) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (frame_done) begin
            if (!valid_q || out_ready) begin
                valid_d = 1'b1;
                data_d  = shift_q;
                err_d   = frame_err;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            sync_q  <= 3'b111;
            smp_q   <= '0;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            zero_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sync_q  <= sync_d;
            smp_q   <= smp_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            zero_q  <= zero_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_error   = err_q;
    assign out_overrun = ovr_q;

endmodule
